// File: rtl/cart_mapper.sv
// cart_mapper: banked cartridge ROM mapper with hotspot bank switching and an optional 128x8 RAM.
module cart_mapper #(
  parameter int          BANKS      = 4,
  parameter int          MODE       = 0,
  parameter logic [11:0] HOT_BASE   = 12'hFF6,
  parameter int          RESET_BANK = BANKS - 1,
  parameter bit          SUPERCHIP  = 1'b0,
  localparam int         BW         = $clog2(BANKS)
) (
  input  logic           MCLK,
  input  logic           RES,
  input  logic           CS,
  input  logic           R_W,
  input  logic [11:0]    A,
  input  logic [7:0]     D_IN,
  input  logic [7:0]     ROM_D,
  output logic [11+BW:0] ROM_ADDR,
  output logic [7:0]     D_OUT,
  output logic [BW-1:0]  BANK
);
  logic [BW-1:0] bank_q, bank_d;
  logic [11:0]   prev_a_q, off;
  logic          prev_cs_q, prev_v_q, new_acc;
  assign new_acc  = CS && (!prev_v_q || !prev_cs_q || prev_a_q != A);
  assign off      = A - HOT_BASE;
  assign ROM_ADDR = {bank_q, A};
  assign BANK     = bank_q;
  // off < BANKS alone bounds the window: HOT_BASE+BANKS-1 never wraps past 12'hFFF
  always_comb begin
    bank_d = bank_q;
    if (new_acc)
      if (MODE == 0)
        bank_d = (off < 12'(BANKS)) ? off[BW-1:0] : bank_q;
      else
        bank_d = (off == 12'd0) ? bank_q + BW'(1) : (off == 12'd1) ? bank_q - BW'(1) : bank_q;
  end
  always_ff @(posedge MCLK) begin
    if (RES) begin
      bank_q   <= BW'(RESET_BANK);
      prev_v_q <= 1'b0;
    end else begin
      bank_q   <= bank_d;
      prev_v_q <= 1'b1;
    end
    prev_cs_q <= CS;
    prev_a_q  <= A;
  end
  if (SUPERCHIP) begin : g_ram
    logic [7:0] ram_q [128];
    always_ff @(posedge MCLK)
      if (CS && !R_W && A[11:7] == 5'd0) ram_q[A[6:0]] <= D_IN;
    assign D_OUT = (CS && R_W && A[11:7] == 5'd1) ? ram_q[A[6:0]] : ROM_D;
  end else begin : g_rom
    logic unused_ok;
    assign unused_ok = ^{D_IN, R_W};
    assign D_OUT     = ROM_D;
  end
endmodule

// File: tb/tb_cart_mapper.sv
// tb_cart_mapper: three mapper configurations on shared stimulus, checked against a bank/RAM model.
module tb_cart_mapper;
  logic        MCLK = 1'b0, RES = 1'b1, CS = 1'b0, R_W = 1'b1;
  logic [11:0] A = '0;
  logic [7:0]  D_IN = '0, ROM_D = '0;
  logic [13:0] ra0, ra2;
  logic [14:0] ra1;
  logic [7:0]  do0, do1, do2;
  logic [1:0]  bk0, bk2;
  logic [2:0]  bk1;
  int checks = 0, failures = 0;
  int m_bank[3];
  bit m_valid = 0, m_lcs = 0;
  logic [11:0] m_la = '0;
  logic [7:0]  m_ram[128];
  bit          m_wr[128];

  cart_mapper u0 (.MCLK(MCLK), .RES(RES), .CS(CS), .R_W(R_W), .A(A), .D_IN(D_IN), .ROM_D(ROM_D),
                  .ROM_ADDR(ra0), .D_OUT(do0), .BANK(bk0));
  cart_mapper #(.BANKS(8), .MODE(1), .HOT_BASE(12'hFF8), .RESET_BANK(7)) u1 (.MCLK(MCLK), .RES(RES),
                  .CS(CS), .R_W(R_W), .A(A), .D_IN(D_IN), .ROM_D(ROM_D), .ROM_ADDR(ra1), .D_OUT(do1), .BANK(bk1));
  cart_mapper #(.SUPERCHIP(1'b1)) u2 (.MCLK(MCLK), .RES(RES), .CS(CS), .R_W(R_W), .A(A), .D_IN(D_IN),
                  .ROM_D(ROM_D), .ROM_ADDR(ra2), .D_OUT(do2), .BANK(bk2));

  always #5 MCLK = ~MCLK;

  task automatic apply(input bit res, input bit cs, input bit rw, input logic [11:0] a,
                       input logic [7:0] d, input logic [7:0] rom);
    RES = res; CS = cs; R_W = rw; A = a; D_IN = d; ROM_D = rom;
    #1;
  endtask

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick;
    int  nb[3];
    bit  nw;
    nb = m_bank;
    nw = CS && (!m_valid || !m_lcs || m_la != A);
    if (RES) nb = '{3, 7, 3};
    else if (nw) begin
      if (A >= 12'hFF6 && A <= 12'hFF9) begin
        nb[0] = int'(A) - 'hFF6;
        nb[2] = nb[0];
      end
      if (A == 12'hFF8) nb[1] = (m_bank[1] + 1) % 8;
      else if (A == 12'hFF9) nb[1] = (m_bank[1] + 7) % 8;
    end
    if (CS && !R_W && A < 12'h080) begin
      m_ram[A[6:0]] = D_IN;
      m_wr[A[6:0]]  = 1'b1;
    end
    m_valid = !RES; m_lcs = CS; m_la = A;
    @(posedge MCLK);
    #1;
    m_bank = nb;
  endtask

  task automatic test_reset;
    apply(1, 0, 1, 12'h000, 8'h00, 8'h11); tick;
    apply(0, 1, 1, 12'h123, 8'h00, 8'h22);
    checks++; if (bk0 !== 2'd3) begin failures++; $display("FAIL reset_bank got=%0d exp=3", bk0); end
    checks++; if (ra0 !== 14'h3123) begin failures++; $display("FAIL reset_rom_addr got=%h exp=3123", ra0); end
    checks++; if (bk1 !== 3'd7) begin failures++; $display("FAIL reset_bank_step got=%0d exp=7", bk1); end
    checks++; if (do0 !== 8'h22) begin failures++; $display("FAIL reset_dout got=%h exp=22", do0); end
    tick;
  endtask

  task automatic test_direct;
    apply(0, 1, 1, 12'hFF7, 8'h00, 8'h33);
    checks++; if (ra0 !== 14'h3FF7) begin failures++; $display("FAIL hotspot_pre_switch got=%h exp=3FF7", ra0); end
    tick;
    apply(0, 1, 1, 12'h200, 8'h00, 8'h33);
    checks++; if (bk0 !== 2'd1) begin failures++; $display("FAIL direct_ff7 got=%0d exp=1", bk0); end
    checks++; if (ra0 !== 14'h1200) begin failures++; $display("FAIL direct_addr got=%h exp=1200", ra0); end
    tick;
    apply(0, 1, 1, 12'hFF9, 8'h00, 8'h33); tick;
    checks++; if (bk0 !== 2'd3) begin failures++; $display("FAIL direct_ff9 got=%0d exp=3", bk0); end
  endtask

  task automatic test_step;
    apply(1, 0, 1, 12'h000, 8'h00, 8'h00); tick;
    apply(0, 1, 1, 12'hFF8, 8'h00, 8'h00); tick; tick; tick;
    checks++; if (bk1 !== 3'd0) begin failures++; $display("FAIL step_held got=%0d exp=0", bk1); end
    apply(0, 1, 1, 12'h000, 8'h00, 8'h00); tick;
    apply(0, 1, 1, 12'hFF8, 8'h00, 8'h00); tick;
    checks++; if (bk1 !== 3'd1) begin failures++; $display("FAIL step_inc got=%0d exp=1", bk1); end
    apply(0, 1, 1, 12'hFF9, 8'h00, 8'h00); tick;
    apply(0, 1, 1, 12'h000, 8'h00, 8'h00); tick;
    apply(0, 1, 1, 12'hFF9, 8'h00, 8'h00); tick;
    checks++; if (bk1 !== 3'd7) begin failures++; $display("FAIL step_dec_wrap got=%0d exp=7", bk1); end
  endtask

  task automatic test_superchip;
    apply(0, 1, 0, 12'h005, 8'hA5, 8'h5A); tick;
    apply(0, 1, 1, 12'h085, 8'h00, 8'h5A);
    checks++; if (do2 !== 8'hA5) begin failures++; $display("FAIL ram_read got=%h exp=A5", do2); end
    apply(0, 1, 1, 12'h005, 8'h00, 8'h5A);
    checks++; if (do2 !== 8'h5A) begin failures++; $display("FAIL ram_low_read got=%h exp=5A", do2); end
    tick;
    apply(0, 1, 0, 12'h085, 8'h3C, 8'h5A); tick;
    apply(0, 1, 1, 12'h085, 8'h00, 8'h5A);
    checks++; if (do2 !== 8'hA5) begin failures++; $display("FAIL ram_high_write got=%h exp=A5", do2); end
    checks++; if (do0 !== 8'h5A) begin failures++; $display("FAIL no_ram_dout got=%h exp=5A", do0); end
    tick;
  endtask

  task automatic test_reset_hotspot;
    apply(0, 1, 1, 12'hFF6, 8'h00, 8'h00); tick;
    apply(1, 1, 1, 12'hFF7, 8'h00, 8'h00); tick;
    checks++; if (bk0 !== 2'd3) begin failures++; $display("FAIL reset_override got=%0d exp=3", bk0); end
    apply(0, 1, 1, 12'h085, 8'h00, 8'h77);
    checks++; if (do2 !== 8'hA5) begin failures++; $display("FAIL ram_kept got=%h exp=A5", do2); end
    tick;
  endtask

  task automatic test_cs_low;
    apply(0, 0, 1, 12'hFF6, 8'h00, 8'h99); tick;
    checks++; if (bk0 !== 2'd3) begin failures++; $display("FAIL cs_low_bank got=%0d exp=3", bk0); end
    checks++; if (do2 !== 8'h99) begin failures++; $display("FAIL cs_low_dout got=%h exp=99", do2); end
  endtask

  task automatic test_random;
    logic [11:0] a;
    logic [7:0]  exp_d;
    bit          known;
    apply(1, 0, 1, 12'h000, 8'h00, 8'h00); tick;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: a = 12'hFF4 + 12'($urandom_range(0, 11));
        1: a = 12'($urandom_range(0, 255));
        2: a = 12'($urandom);
        default: a = A;
      endcase
      apply($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0, 1'($urandom), a,
            8'($urandom), 8'($urandom));
      known = 1'b1;
      exp_d = ROM_D;
      if (CS && R_W && A >= 12'h080 && A <= 12'h0FF) begin
        known = m_wr[A[6:0]];
        exp_d = m_ram[A[6:0]];
      end
      checks++; if (ra0 !== 14'(m_bank[0] * 4096 + int'(A))) begin failures++; $display("FAIL rnd_addr0 i=%0d got=%h exp_bank=%0d", i, ra0, m_bank[0]); end
      checks++; if (ra1 !== 15'(m_bank[1] * 4096 + int'(A))) begin failures++; $display("FAIL rnd_addr1 i=%0d got=%h exp_bank=%0d", i, ra1, m_bank[1]); end
      checks++; if (ra2 !== 14'(m_bank[2] * 4096 + int'(A))) begin failures++; $display("FAIL rnd_addr2 i=%0d got=%h exp_bank=%0d", i, ra2, m_bank[2]); end
      checks++; if (do1 !== ROM_D) begin failures++; $display("FAIL rnd_dout1 i=%0d got=%h exp=%h", i, do1, ROM_D); end
      if (known) begin
        checks++; if (do2 !== exp_d) begin failures++; $display("FAIL rnd_dout2 i=%0d a=%h got=%h exp=%h", i, A, do2, exp_d); end
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_direct;
    test_step;
    test_superchip;
    test_reset_hotspot;
    test_cs_low;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
